// File: rtl/dspl_src_sched.sv
`timescale 1ns/1ps
// Display source scheduler: picks clock time, setting view (with per-digit blink)
// or a handshaked transient message for the 8-digit seven-segment driver.
//
//   state  | meaning
//   S_TIME | background: show running clock time
//   S_SET  | setting mode: show set_dig, masked digits blink
//   S_MSG  | show latched message until the hold timer expires
module dspl_src_sched #(
  parameter int TICK_COUNT = 100000,
  parameter int BLINK_MS   = 250,
  parameter int MSG_MS     = 2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [47:0] time_dig,
  input  logic        set_active,
  input  logic [47:0] set_dig,
  input  logic [7:0]  blink_mask,
  input  logic        msg_req,
  input  logic [47:0] msg_dig,
  output logic        msg_ack,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8,
  output logic [1:0]  src_sel
);

  localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int MW = $clog2(MSG_MS + 1);

  typedef enum logic [1:0] {
    S_TIME = 2'b00,
    S_SET  = 2'b01,
    S_MSG  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] pre_cnt;
  logic          tick;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic [MW-1:0] msg_tmr;
  logic [47:0]   msg_buf;
  logic [47:0]   set_view;
  logic [47:0]   d_q;
  logic          accept;
  logic          expire;
  logic          enter_set;

  assign tick = (pre_cnt == TW'(TICK_COUNT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pre_cnt <= '0;
    else       pre_cnt <= tick ? '0 : pre_cnt + TW'(1);
  end

  always_comb begin
    accept    = msg_req && !msg_ack;
    expire    = (state_q == S_MSG) && tick && (msg_tmr == MW'(1));
    state_d   = state_q;
    case (state_q)
      S_TIME: begin
        if (msg_req)         state_d = S_MSG;
        else if (set_active) state_d = S_SET;
      end
      S_SET: begin
        if (msg_req)          state_d = S_MSG;
        else if (!set_active) state_d = S_TIME;
      end
      S_MSG: begin
        // a request arriving with expiry keeps the message view and relatches
        if (expire && !msg_req) state_d = set_active ? S_SET : S_TIME;
      end
      default: state_d = S_TIME;
    endcase
    enter_set = (state_d == S_SET) && (state_q != S_SET);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_TIME;
      msg_ack <= 1'b0;
      msg_buf <= '0;
      msg_tmr <= '0;
    end else begin
      state_q <= state_d;
      msg_ack <= accept;
      if (accept) begin
        msg_buf <= msg_dig;
        msg_tmr <= MW'(MSG_MS);
      end else if ((state_q == S_MSG) && tick && (msg_tmr != '0)) begin
        msg_tmr <= msg_tmr - MW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (enter_set) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // only the enable bit is dropped so value and dp are stable across blink
  always_comb begin
    set_view = set_dig;
    for (int i = 0; i < 8; i++) begin
      if (blink_off && blink_mask[i]) set_view[6*i+5] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_q     <= {8{6'b000001}};
      src_sel <= 2'b00;
    end else begin
      case (state_q)
        S_SET:   d_q <= set_view;
        S_MSG:   d_q <= msg_buf;
        default: d_q <= time_dig;
      endcase
      src_sel <= state_q;
    end
  end

  assign d1 = d_q[5:0];
  assign d2 = d_q[11:6];
  assign d3 = d_q[17:12];
  assign d4 = d_q[23:18];
  assign d5 = d_q[29:24];
  assign d6 = d_q[35:30];
  assign d7 = d_q[41:36];
  assign d8 = d_q[47:42];

endmodule

// File: tb/tb_dspl_src_sched.sv
`timescale 1ns/1ps
// Bench for dspl_src_sched: vector table for source muxing, a message scoreboard,
// and hand-written sequences for blink timing, relatch at expiry and mid-hold reset.
module tb_dspl_src_sched;

  localparam int TC = 4;
  localparam int BM = 3;
  localparam int MM = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic [47:0] time_dig;
  logic        set_active;
  logic [47:0] set_dig;
  logic [7:0]  blink_mask;
  logic        msg_req;
  logic [47:0] msg_dig;
  logic        msg_ack;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [1:0]  src_sel;
  logic [47:0] dall;

  assign dall = {d8, d7, d6, d5, d4, d3, d2, d1};

  dspl_src_sched #(.TICK_COUNT(TC), .BLINK_MS(BM), .MSG_MS(MM)) dut (
    .clock(clock), .reset(reset), .time_dig(time_dig), .set_active(set_active),
    .set_dig(set_dig), .blink_mask(blink_mask), .msg_req(msg_req), .msg_dig(msg_dig),
    .msg_ack(msg_ack), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .d7(d7), .d8(d8), .src_sel(src_sel)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_cnt = 0;
  logic ack_prev = 1'b0;
  logic [47:0] exp_q[$];

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: each ack must be followed next cycle by the queued message on display.
  initial forever begin
    @(negedge clock);
    if (ack_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL msg_scoreboard: got unexpected ack want none");
      end else begin
        chk("msg_display", dall, exp_q.pop_front());
      end
    end
    if (msg_ack) begin
      ack_cnt++;
      chk("ack_gap", ack_prev, 1'b0);
    end
    ack_prev = msg_ack;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [47:0] pat(input logic [3:0] b, input logic en);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[6*i +: 6] = {en, b + 4'(i), 1'b1};
    return r;
  endfunction

  typedef struct {
    logic        sa;
    logic [47:0] td;
    logic [47:0] sd;
    logic [7:0]  mask;
    logic [1:0]  sel;
    logic [47:0] dexp;
  } vec_t;

  vec_t vecs[8];

  localparam logic [47:0] SET5 = {8{6'b101011}};

  initial begin
    int n, r1, r2, r3, idx, exit_cyc, a_edge, t1, t5, x_edge, a0;
    logic ok, bits[40];
    logic [47:0] m2, m3;

    vecs[0] = '{1'b0, pat(4'h0, 1'b1), pat(4'h3, 1'b1), 8'hff, 2'b00, pat(4'h0, 1'b1)};
    vecs[1] = '{1'b1, pat(4'h0, 1'b1), pat(4'h3, 1'b1), 8'hff, 2'b01, pat(4'h3, 1'b1)};
    vecs[2] = '{1'b0, pat(4'h8, 1'b1), pat(4'h3, 1'b1), 8'h00, 2'b00, pat(4'h8, 1'b1)};
    vecs[3] = '{1'b1, pat(4'h8, 1'b1), pat(4'hA, 1'b0), 8'h00, 2'b01, pat(4'hA, 1'b0)};
    vecs[4] = '{1'b1, pat(4'h8, 1'b1), pat(4'h1, 1'b1), 8'h5A, 2'b01, pat(4'h1, 1'b1)};
    vecs[5] = '{1'b0, pat(4'hC, 1'b0), pat(4'h1, 1'b1), 8'h5A, 2'b00, pat(4'hC, 1'b0)};
    vecs[6] = '{1'b0, 48'h0,           pat(4'h1, 1'b1), 8'h00, 2'b00, 48'h0};
    vecs[7] = '{1'b1, 48'h0,           48'hffff_ffff_ffff, 8'h00, 2'b01, 48'hffff_ffff_ffff};

    reset = 1'b1;
    time_dig = 48'h2A2B_2C2D_2E2F;
    set_active = 1'b0;
    set_dig = '0;
    blink_mask = '0;
    msg_req = 1'b0;
    msg_dig = '0;
    step(3);
    chk("reset_digits", dall, {8{6'b000001}});
    chk("reset_src", src_sel, 2'b00);
    chk("reset_ack", msg_ack, 1'b0);
    reset = 1'b0;
    step(2);
    chk("release_digits", dall, 48'h2A2B_2C2D_2E2F);
    chk("release_src", src_sel, 2'b00);

    foreach (vecs[i]) begin
      set_active = vecs[i].sa;
      time_dig = vecs[i].td;
      set_dig = vecs[i].sd;
      blink_mask = vecs[i].mask;
      step(2);
      chk($sformatf("vec%0d_src", i), src_sel, vecs[i].sel);
      chk($sformatf("vec%0d_digits", i), dall, vecs[i].dexp);
    end

    // Blink: first ON span 9..12 cycles (tick phase unaligned), then exact 12/12.
    set_active = 1'b0;
    step(3);
    set_dig = SET5;
    blink_mask = 8'h03;
    set_active = 1'b1;
    step(1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      bits[i] = d1[5];
      if (d2[5] !== d1[5] || d1[4:0] !== 5'b01011 || d2[4:0] !== 5'b01011 ||
          dall[47:12] !== SET5[47:12] || src_sel !== 2'b01) ok = 1'b0;
    end
    idx = 0; r1 = 0; r2 = 0; r3 = 0;
    while (idx < 40 && bits[idx] === 1'b1) begin r1++; idx++; end
    while (idx < 40 && bits[idx] === 1'b0) begin r2++; idx++; end
    while (idx < 40 && bits[idx] === 1'b1) begin r3++; idx++; end
    chk("blink_first_on_9_to_12", (r1 >= 9 && r1 <= 12), 1'b1);
    chk("blink_off_len", r2, 12);
    chk("blink_on_len", r3, 12);
    chk("blink_other_bits", ok, 1'b1);
    blink_mask = 8'h80;
    step(1);
    chk("mask_change_d1d2_on", {d2[5], d1[5]}, 2'b11);

    // Single message from S_TIME; msg_dig changes after ack must not show.
    set_active = 1'b0;
    blink_mask = 8'h00;
    time_dig = pat(4'h2, 1'b1);
    step(3);
    msg_dig = {8{6'b111101}};
    msg_req = 1'b1;
    exp_q.push_back({8{6'b111101}});
    step(1);
    chk("ack_after_req", msg_ack, 1'b1);
    msg_req = 1'b0;
    msg_dig = pat(4'h7, 1'b1);
    n = 0;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (src_sel !== 2'b10) break;
      n++;
      if (dall !== {8{6'b111101}}) ok = 1'b0;
    end
    x_edge = cyc - 1;
    chk("msg_hold_17_to_20", (n >= 17 && n <= 20), 1'b1);
    chk("msg_buffer_stable", ok, 1'b1);
    chk("msg_return_src", src_sel, 2'b00);
    chk("msg_return_digits", dall, pat(4'h2, 1'b1));

    // Second request lands exactly on the expiry tick: relatch, full-length hold.
    step(2);
    m2 = pat(4'h4, 1'b1);
    m3 = pat(4'hB, 1'b0);
    msg_dig = m2;
    msg_req = 1'b1;
    exp_q.push_back(m2);
    a_edge = cyc + 1;
    t1 = a_edge + 1;
    while ((t1 - x_edge) % TC != 0) t1++;
    t5 = t1 + TC * (MM - 1);
    exit_cyc = -1;
    for (int i = 0; i < 80 && exit_cyc < 0; i++) begin
      step(1);
      if (cyc == a_edge) msg_req = 1'b0;
      if (cyc == t5 - 1) begin
        msg_dig = m3;
        msg_req = 1'b1;
        exp_q.push_back(m3);
      end
      if (cyc == t5) begin
        msg_req = 1'b0;
        msg_dig = pat(4'h9, 1'b1);
        chk("relatch_ack", msg_ack, 1'b1);
      end
      if (cyc > a_edge && src_sel !== 2'b10) exit_cyc = cyc;
    end
    chk("relatch_exit_cycle", exit_cyc, t5 + TC * MM + 1);

    // Message during setting mode returns to S_SET with blink restarted ON.
    set_dig = SET5;
    blink_mask = 8'h03;
    set_active = 1'b1;
    step(4);
    msg_dig = pat(4'h6, 1'b1);
    msg_req = 1'b1;
    exp_q.push_back(pat(4'h6, 1'b1));
    step(1);
    msg_req = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (src_sel === 2'b10) n++;
      else if (n > 0) break;
    end
    chk("set_msg_hold_17_to_20", (n >= 17 && n <= 20), 1'b1);
    chk("set_msg_return_src", src_sel, 2'b01);
    ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (d1[5] !== 1'b1 || d2[5] !== 1'b1) ok = 1'b0;
      step(1);
    end
    chk("set_blink_restart_on", ok, 1'b1);

    // Held request: re-acked every other cycle.
    set_active = 1'b0;
    step(3);
    a0 = ack_cnt;
    msg_dig = pat(4'h5, 1'b0);
    exp_q.push_back(pat(4'h5, 1'b0));
    exp_q.push_back(pat(4'h5, 1'b0));
    msg_req = 1'b1;
    step(4);
    msg_req = 1'b0;
    step(2);
    chk("held_req_acks", ack_cnt - a0, 2);
    for (int i = 0; i < 40; i++) begin
      if (src_sel === 2'b00) break;
      step(1);
    end
    chk("held_req_return", src_sel, 2'b00);

    // Reset in the middle of a message hold.
    step(2);
    msg_dig = pat(4'hD, 1'b1);
    msg_req = 1'b1;
    exp_q.push_back(pat(4'hD, 1'b1));
    step(1);
    msg_req = 1'b0;
    step(6);
    chk("pre_reset_in_msg", src_sel, 2'b10);
    #2 reset = 1'b1;
    #1;
    chk("midreset_digits", dall, {8{6'b000001}});
    chk("midreset_src", src_sel, 2'b00);
    chk("midreset_ack", msg_ack, 1'b0);
    step(3);
    reset = 1'b0;
    step(2);
    chk("after_reset_src", src_sel, 2'b00);
    chk("after_reset_digits", dall, pat(4'h2, 1'b1));
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (src_sel === 2'b10 || msg_ack === 1'b1) n++;
    end
    chk("no_msg_replay", n, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dspl_src_sched.md
Name: dspl_src_sched

Overview:
- Schedules what the 8-digit seven-segment driver shows in the digital clock.
- Arbitrates between three display sources: running clock time (background), time-setting view (with per-digit blink), and a transient message (handshaked, timed hold).
- Outputs registered d8..d1 digit vectors in the driver's 6-bit format: bit5 = enable (active-high), bits4:1 = hex value, bit0 = decimal point (active-low).

Parameters:
TICK_COUNT, 100000, clock cycles per 1 ms tick (100 MHz system clock)
BLINK_MS, 250, blink half-period in ticks
MSG_MS, 2000, message hold time in ticks

Ports:
clock  input  1  100 MHz system clock
reset  input  1  asynchronous, active-high reset
time_dig  input  48  clock-time digits, packed: digit i in bits [6i-1:6i-6], so d1 = [5:0] and d8 = [47:42]
set_active  input  1  level; setting mode active
set_dig  input  48  setting-view digits, same packing
blink_mask  input  8  bit i-1 set means digit i blinks in setting mode
msg_req  input  1  message request (level or pulse)
msg_dig  input  48  message digits, sampled when msg_ack is asserted
msg_ack  output  1  one-cycle acknowledge, message latched
d1..d8  output  6 each  digit vectors to the display driver (registered)
src_sel  output  2  current source: 00 time, 01 set, 10 msg

Behaviour:
Reset state:
- state = S_TIME; src_sel = 00; msg_ack = 0.
- d1..d8 = 6'b000001 (disabled, dp off).
- Tick prescaler, blink counter, blink phase and message timer all cleared.

Tick prescaler:
- Free-running counter 0..TICK_COUNT-1.
- tick pulses for one cycle when the counter wraps.

States and priority (msg > set > time), evaluated every cycle:
- S_TIME: if msg_req, go to S_MSG; else if set_active, go to S_SET.
- S_SET: if msg_req, go to S_MSG; else if !set_active, go to S_TIME.
- S_MSG, timer expired: go to S_SET if set_active, else S_TIME. Same cycle: if msg_req is also high, relatch instead.
- S_MSG, msg_req high: relatch msg_dig, pulse msg_ack, reload timer.

Message acceptance:
- In the cycle msg_req is seen high with msg_ack low, msg_dig is copied into an internal buffer and msg_ack = 1 next cycle.
- msg_ack is never high on two consecutive cycles. A held-high msg_req is re-acked every other cycle, and each ack reloads the timer.

Message timer:
- Loaded with MSG_MS on accept; decrements on tick.
- Expiry occurs when the value is 1 and tick is high.
- Hold duration: MSG_MS ticks, minus up to one tick period (tick phase is not aligned to the accept).

Blink:
- Blink counter counts ticks 0..BLINK_MS-1 and toggles blink phase at wrap.
- Entering S_SET from any state clears the counter and sets phase = ON.
- Phase = OFF: every digit with its blink_mask bit set has bit5 forced to 0. All other bits pass through.
- Phase = ON: set_dig passes through unmodified.
- blink_mask changes take effect on the next output update without resetting the phase.

Output:
- d1..d8 and src_sel are registered.
- They reflect the state and source data one cycle after the state register updates, i.e. 2 cycles from a msg_req or set_active edge.
- S_TIME tracks time_dig continuously with 1-cycle latency.
- S_MSG shows the buffered message, not live msg_dig.

Reset mid-operation:
- Immediately returns all outputs and state to reset values.
- Any pending message is discarded.

Test Plan:
- Reset, then time_dig = 0x_2A_2B... packed pattern -> d1..d8 = 000001 during reset; 2 cycles after release they equal time_dig fields; src_sel = 00.
- TICK_COUNT=4, BLINK_MS=3: set_active=1, blink_mask=8'h03, set_dig all digits enabled value 5 -> src_sel = 01; d1 and d2 bit5 toggle every 12 cycles starting ON; d3..d8 stay enabled.
- MSG_MS=5, TICK_COUNT=4: single-cycle msg_req in S_TIME with msg_dig = digits 0xE -> msg_ack one cycle later; src_sel = 10 for 17-20 cycles; msg_dig changes after ack do not alter output; then returns to 00.
- msg_req issued during S_SET with set_active held -> S_MSG; after expiry returns to S_SET with blink phase restarting ON.
- Second msg_req at timer = 1 coincident with tick -> no exit; new message latched; hold restarts at full length; exactly one msg_ack per accept.
- Assert reset while in S_MSG with timer mid-count -> outputs 000001, msg_ack = 0; after release shows time source; no message replay.
